// File: rtl/pic_cpu_master.sv
// CPU-side master for an 8259-style PIC: runs the ICW/OCW init sequence, then
// answers interrupts with a two-pulse INTA cycle. Define PIC_AUTO_EOI_EN to append an OCW2 EOI write.
module pic_cpu_master #(
  parameter int INTA_LOW = 2,
  parameter int INTA_GAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] ocw1,
  input  logic       INT,
  inout  wire  [7:0] data_bus,
  output logic       WD,
  output logic       RD,
  output logic       A0,
  output logic       INTA,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  output logic       busy,
  output logic       init_done
);

  typedef enum logic [3:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, READY, INTA1, GAP, INTA2, CAPTURE
  } state_t;

  typedef enum logic [2:0] {
    WR_ICW1, WR_ICW2, WR_ICW3, WR_ICW4, WR_OCW1, WR_EOI, WR_NONE
  } wr_t;

  localparam logic [3:0] LOW_LAST = 4'(INTA_LOW - 1);
  localparam logic [3:0] GAP_LAST = 4'(INTA_GAP - 1);
`ifdef PIC_AUTO_EOI_EN
  localparam logic [7:0] EOI_CMD  = 8'h20;
`endif

  state_t     state;
  wr_t        wr_sel;
  wr_t        wr_next;
  logic [7:0] wr_next_byte;
  logic       wr_next_a0;
  logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q;
  logic [7:0] dout;
  logic       doe;
  logic [3:0] cnt;

  assign data_bus = doe ? dout : 8'hzz;
  assign RD       = 1'b1;

  // ICW3 exists only in cascade mode (SNGL=0); ICW4 only when IC4=1
  always_comb begin
    wr_next = WR_NONE;
    case (wr_sel)
      WR_ICW1: wr_next = WR_ICW2;
      WR_ICW2: begin
        if (!icw1_q[1])     wr_next = WR_ICW3;
        else if (icw1_q[0]) wr_next = WR_ICW4;
        else                wr_next = WR_OCW1;
      end
      WR_ICW3: wr_next = icw1_q[0] ? WR_ICW4 : WR_OCW1;
      WR_ICW4: wr_next = WR_OCW1;
      default: wr_next = WR_NONE;
    endcase
  end

  always_comb begin
    wr_next_byte = 8'h00;
    case (wr_next)
      WR_ICW1: wr_next_byte = icw1_q;
      WR_ICW2: wr_next_byte = icw2_q;
      WR_ICW3: wr_next_byte = icw3_q;
      WR_ICW4: wr_next_byte = icw4_q;
      WR_OCW1: wr_next_byte = ocw1_q;
      default: wr_next_byte = 8'h00;
    endcase
    wr_next_a0 = !(wr_next inside {WR_ICW1, WR_EOI});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_sel       <= WR_ICW1;
      icw1_q       <= 8'h00;
      icw2_q       <= 8'h00;
      icw3_q       <= 8'h00;
      icw4_q       <= 8'h00;
      ocw1_q       <= 8'h00;
      dout         <= 8'h00;
      doe          <= 1'b0;
      cnt          <= 4'd0;
      WD           <= 1'b1;
      A0           <= 1'b0;
      INTA         <= 1'b1;
      vector_out   <= 8'h00;
      vector_valid <= 1'b0;
      busy         <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      vector_valid <= 1'b0;
      case (state)
        IDLE, READY: begin
          // start takes priority over a pending INT
          if (start) begin
            icw1_q    <= icw1;
            icw2_q    <= icw2;
            icw3_q    <= icw3;
            icw4_q    <= icw4;
            ocw1_q    <= ocw1;
            wr_sel    <= WR_ICW1;
            dout      <= icw1;
            A0        <= 1'b0;
            doe       <= 1'b1;
            busy      <= 1'b1;
            init_done <= 1'b0;
            state     <= W_SETUP;
          end else if (state == READY && INT) begin
            INTA      <= 1'b0;
            cnt       <= LOW_LAST;
            busy      <= 1'b1;
            init_done <= 1'b0;
            state     <= INTA1;
          end
        end
        W_SETUP: begin
          WD    <= 1'b0;
          state <= W_STROBE;
        end
        W_STROBE: begin
          WD    <= 1'b1;
          state <= W_HOLD;
        end
        W_HOLD: begin
          if (wr_next == WR_NONE) begin
            doe       <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b1;
            state     <= READY;
          end else begin
            wr_sel <= wr_next;
            dout   <= wr_next_byte;
            A0     <= wr_next_a0;
            state  <= W_SETUP;
          end
        end
        INTA1: begin
          if (cnt == 4'd0) begin
            INTA  <= 1'b1;
            cnt   <= GAP_LAST;
            state <= GAP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        GAP: begin
          if (cnt == 4'd0) begin
            INTA  <= 1'b0;
            cnt   <= LOW_LAST;
            state <= INTA2;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        INTA2: begin
          if (cnt == 4'd0) begin
            INTA         <= 1'b1;
            vector_out   <= data_bus;
            vector_valid <= 1'b1;
            state        <= CAPTURE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        CAPTURE: begin
`ifdef PIC_AUTO_EOI_EN
          wr_sel <= WR_EOI;
          dout   <= EOI_CMD;
          A0     <= 1'b0;
          doe    <= 1'b1;
          state  <= W_SETUP;
`else
          busy      <= 1'b0;
          init_done <= 1'b1;
          state     <= READY;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_cpu_master.sv
// Bench for pic_cpu_master: queue-based expected-trace model compared every cycle,
// directed literal scenarios, then randomized start/INT/reset traffic.
module tb_pic_cpu_master;
  localparam int L = 2;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       INT = 1'b0;
  logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00, ocw1 = 8'h00;
  wire  [7:0] data_bus;
  logic       WD, RD, A0, INTA, vector_valid, busy, init_done;
  logic [7:0] vector_out;
  logic [7:0] pic_vec = 8'hF6;

  pic_cpu_master #(.INTA_LOW(L), .INTA_GAP(G)) dut (
    .clk(clk), .reset(reset), .start(start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1),
    .INT(INT), .data_bus(data_bus), .WD(WD), .RD(RD), .A0(A0), .INTA(INTA),
    .vector_out(vector_out), .vector_valid(vector_valid),
    .busy(busy), .init_done(init_done)
  );

  // PIC side: drives the vector while INTA is low; released bus floats high
  assign data_bus = (INTA == 1'b0) ? pic_vec : 8'hzz;
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (data_bus[gi]);
  end

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs per cycle, as a queue of future cycles
  typedef struct packed {
    logic       wd;
    logic       a0;
    logic       oe;
    logic [7:0] d;
    logic       inta;
    logic       busy;
    logic       vv;
  } ent_t;

  localparam ent_t REST = '{wd:1'b1, a0:1'b0, oe:1'b0, d:8'h00, inta:1'b1, busy:1'b0, vv:1'b0};

  ent_t       q[$];
  ent_t       ex = REST;
  logic       m_ready = 1'b0;
  logic [7:0] exp_vec = 8'h00;
  logic [8:0] wlog[$];

  task automatic push_wr(input logic [7:0] d, input logic a0);
    q.push_back('{wd:1'b1, a0:a0, oe:1'b1, d:d, inta:1'b1, busy:1'b1, vv:1'b0});
    q.push_back('{wd:1'b0, a0:a0, oe:1'b1, d:d, inta:1'b1, busy:1'b1, vv:1'b0});
    q.push_back('{wd:1'b1, a0:a0, oe:1'b1, d:d, inta:1'b1, busy:1'b1, vv:1'b0});
  endtask

  task automatic push_inta(input logic lvl, input int n);
    for (int i = 0; i < n; i++)
      q.push_back('{wd:1'b1, a0:1'b0, oe:1'b0, d:8'h00, inta:lvl, busy:1'b1, vv:1'b0});
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      ex      = REST;
      m_ready = 1'b0;
      exp_vec = 8'h00;
    end else begin
      if (!ex.busy) begin
        if (start) begin
          push_wr(icw1, 1'b0);
          push_wr(icw2, 1'b1);
          if (!icw1[1]) push_wr(icw3, 1'b1);
          if (icw1[0])  push_wr(icw4, 1'b1);
          push_wr(ocw1, 1'b1);
          m_ready = 1'b1;
        end else if (m_ready && INT) begin
          push_inta(1'b0, L);
          push_inta(1'b1, G);
          push_inta(1'b0, L);
          q.push_back('{wd:1'b1, a0:1'b0, oe:1'b0, d:8'h00, inta:1'b1, busy:1'b1, vv:1'b1});
`ifdef PIC_AUTO_EOI_EN
          push_wr(8'h20, 1'b0);
`endif
        end
      end
      if (q.size() > 0) ex = q.pop_front();
      else              ex = REST;
      if (ex.vv) exp_vec = pic_vec;
    end
  end

  always @(posedge clk) begin
    #2;
    chk("WD", {8'h00, WD}, {8'h00, ex.wd});
    chk("RD", {8'h00, RD}, 9'h001);
    chk("INTA", {8'h00, INTA}, {8'h00, ex.inta});
    chk("busy", {8'h00, busy}, {8'h00, ex.busy});
    chk("init_done", {8'h00, init_done}, {8'h00, (!ex.busy && m_ready)});
    chk("vector_valid", {8'h00, vector_valid}, {8'h00, ex.vv});
    chk("vector_out", {1'b0, vector_out}, {1'b0, exp_vec});
    if (ex.oe) begin
      chk("A0", {8'h00, A0}, {8'h00, ex.a0});
      chk("data_bus", {1'b0, data_bus}, {1'b0, ex.d});
    end else if (ex.inta) begin
      chk("bus_release", {1'b0, data_bus}, 9'h0FF);
    end
    if (WD == 1'b0) wlog.push_back({A0, data_bus});
  end

  task automatic pulse_start(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                             input logic [7:0] b4, input logic [7:0] b5);
    @(negedge clk);
    icw1 = b1; icw2 = b2; icw3 = b3; icw4 = b4; ocw1 = b5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in the first write cycle; READY must appear exactly n edges after acceptance
  task automatic init_timing(input string nm, input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == n - 1) chk({nm, "_done_early"}, {8'h00, init_done}, 9'h000);
      if (k == n)     chk({nm, "_done"}, {8'h00, init_done}, 9'h001);
    end
  endtask

  task automatic wait_ready(input string nm);
    int k;
    k = 0;
    while (!init_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_ready_timeout"}, {8'h00, init_done}, 9'h001);
  endtask

  logic [8:0] exp1[5] = '{9'h015, 9'h1F8, 9'h1FF, 9'h11F, 9'h100};
  logic [8:0] exp2[3] = '{9'h012, 9'h140, 9'h10C};
  logic [5:0] seq;
  logic       found;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_A0", {8'h00, A0}, 9'h000);
    chk("rst_WD", {8'h00, WD}, 9'h001);
    chk("rst_INTA", {8'h00, INTA}, 9'h001);
    chk("rst_busy", {8'h00, busy}, 9'h000);
    chk("rst_bus", {1'b0, data_bus}, 9'h0FF);
    reset = 1'b0;

    // Full init: five writes, READY 15 edges after start
    wlog.delete();
    pulse_start(8'h15, 8'hF8, 8'hFF, 8'h1F, 8'h00);
    init_timing("t1", 15);
    chk("t1_nwr", 9'(wlog.size()), 9'd5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) chk("t1_wr", wlog[i], exp1[i]);

    // Minimum init: SNGL=1, IC4=0
    wlog.delete();
    pulse_start(8'h12, 8'h40, 8'hAA, 8'h55, 8'h0C);
    init_timing("t2", 9);
    chk("t2_nwr", 9'(wlog.size()), 9'd3);
    for (int i = 0; i < 3 && i < wlog.size(); i++) chk("t2_wr", wlog[i], exp2[i]);

    // Interrupt acknowledge with vector F6
    wlog.delete();
    pic_vec = 8'hF6;
    @(negedge clk); INT = 1'b1;
    @(negedge clk); INT = 1'b0;
    seq[0] = INTA;
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      seq[i] = INTA;
    end
    chk("t3_inta_seq", {3'b000, seq}, 9'b000_100100);
    chk("t3_vv", {8'h00, vector_valid}, 9'h001);
    chk("t3_vec", {1'b0, vector_out}, 9'h0F6);
    @(negedge clk);
    chk("t3_vv_once", {8'h00, vector_valid}, 9'h000);
`ifdef PIC_AUTO_EOI_EN
    repeat (3) @(negedge clk);
    chk("t3_eoi_n", 9'(wlog.size()), 9'd1);
    if (wlog.size() > 0) chk("t3_eoi", wlog[0], 9'h020);
`endif
    wait_ready("t3");

    // INT dropped during GAP: acknowledge still completes
    @(negedge clk); INT = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t4_in_gap", {8'h00, INTA}, 9'h001);
    INT = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (vector_valid) found = 1'b1;
    end
    chk("t4_capture", {8'h00, found}, 9'h001);
    wait_ready("t4");

    // start during INTA1 is ignored; a later start re-runs full init
    wlog.delete();
    @(negedge clk); INT = 1'b1;
    @(negedge clk); INT = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_ready("t5");
`ifdef PIC_AUTO_EOI_EN
    chk("t5_no_init", 9'(wlog.size()), 9'd1);
`else
    chk("t5_no_init", 9'(wlog.size()), 9'd0);
`endif
    wlog.delete();
    pulse_start(8'h15, 8'hF8, 8'hFF, 8'h1F, 8'h00);
    init_timing("t5", 15);
    chk("t5_nwr", 9'(wlog.size()), 9'd5);

    // Reset in the ICW2 strobe cycle releases strobe and bus immediately
    pulse_start(8'h15, 8'hF8, 8'hFF, 8'h1F, 8'h00);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (WD == 1'b0 && A0 == 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    chk("t6_found_strobe", {8'h00, found}, 9'h001);
    #1 reset = 1'b1;
    #1;
    chk("t6_WD", {8'h00, WD}, 9'h001);
    chk("t6_bus", {1'b0, data_bus}, 9'h0FF);
    chk("t6_busy", {8'h00, busy}, 9'h000);
    @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("t6_idle_busy", {8'h00, busy}, 9'h000);
    chk("t6_idle_done", {8'h00, init_done}, 9'h000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset   = ($urandom % 400) == 0;
      start   = ($urandom % 10) == 0;
      INT     = ($urandom % 3) == 0;
      icw1    = 8'($urandom);
      icw2    = 8'($urandom);
      icw3    = 8'($urandom);
      icw4    = 8'($urandom);
      ocw1    = 8'($urandom);
      pic_vec = 8'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; INT = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/pic_cpu_master.md
PIC_CPU_MASTER -- requirements
Module: pic_cpu_master

Interface
REQ-001 Parameter INTA_LOW, default 2: number of cycles each INTA pulse is held low (legal range 1..15).
REQ-002 Parameter INTA_GAP, default 1: number of high cycles between the two INTA pulses (legal range 1..15).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to run the init sequence; ignored while busy.
REQ-006 icw1, icw2, icw3, icw4, ocw1  input  8 each  programming bytes, sampled on the accepted start.
REQ-007 INT  input  1  interrupt request from the PIC.
REQ-008 data_bus  inout  8  PIC data bus; driven only during write states, high-Z otherwise.
REQ-009 WD  output  1  active-low write strobe.
REQ-010 RD  output  1  active-low read strobe; held 1 by this block.
REQ-011 A0  output  1  PIC address bit.
REQ-012 INTA  output  1  active-low interrupt acknowledge.
REQ-013 vector_out  output  8  captured interrupt vector.
REQ-014 vector_valid  output  1  one-cycle pulse when vector_out updates.
REQ-015 busy  output  1  high in any state other than IDLE or READY.
REQ-016 init_done  output  1  high in READY.

Function
REQ-017 States: IDLE, W_SETUP, W_STROBE, W_HOLD, READY, INTA1, GAP, INTA2, CAPTURE.
- Each byte write takes exactly 3 cycles:
  - W_SETUP: A0 and data driven, WD=1.
  - W_STROBE: WD=0.
  - W_HOLD: WD=1, data still driven.
REQ-018 Write order and A0 values:
- ICW1 with A0=0.
- ICW2 with A0=1.
- ICW3 with A0=1, skipped when icw1[1]=1.
- ICW4 with A0=1, skipped when icw1[0]=0.
- OCW1 with A0=1.
- Then enter READY.
REQ-019 A start accepted in IDLE or READY enters W_SETUP on the next edge; start in any other state is ignored.
REQ-020 Full init (5 writes) takes 15 cycles from start to READY; minimum init (3 writes) takes 9 cycles.
REQ-021 In READY, INT sampled high starts INTA1 on the next edge; INT low leaves the block in READY.
REQ-022 INTA1 holds INTA=0 for INTA_LOW cycles, then GAP holds INTA=1 for INTA_GAP cycles, then INTA2 holds INTA=0 for INTA_LOW cycles.
REQ-023 data_bus is sampled on the last cycle of INTA2 into vector_out; CAPTURE pulses vector_valid for one cycle.
REQ-024 Once INTA1 has begun, the acknowledge sequence runs to completion even if INT falls.
REQ-025 After CAPTURE the block returns to READY (EOI handling per REQ-030).
REQ-026 start coincident with INT in READY: start wins and the block re-initialises.
REQ-027 WD, INTA, and the data_bus enable are registered; no combinational path from inputs to strobes.

Reset
REQ-028 Reset asserted, including mid-write or mid-INTA, takes effect immediately and asynchronously:
- State = IDLE.
- WD=1, RD=1, INTA=1, A0=0.
- data_bus released to high-Z.
- vector_out=8'h00, vector_valid=0, busy=0, init_done=0.
REQ-029 Latched programming bytes are cleared to 8'h00 on reset.

Configuration
REQ-030 Macro PIC_AUTO_EOI_EN:
- Defined: after CAPTURE the block issues a 3-cycle OCW2 write of 8'h20 (non-specific EOI) with A0=0, then enters READY; busy stays high throughout the EOI write.
- Undefined: CAPTURE goes directly to READY and no EOI write occurs.

Verification
REQ-031 reset, then start with icw1=8'h15, icw2=8'hF8, icw3=8'hFF, icw4=8'h1F, ocw1=8'h00 -> five WD low pulses carrying 15,F8,FF,1F,00 with A0=0,1,1,1,1; init_done high 15 cycles after start.
REQ-032 start with icw1=8'h12 (SNGL=1, IC4=0) -> only ICW1, ICW2, OCW1 written; READY 9 cycles after start.
REQ-033 In READY, INT=1 with the PIC driving 8'hF6 during INTA2 (defaults) -> INTA low 2 cycles, high 1 cycle, low 2 cycles; vector_out=8'hF6 with vector_valid pulsed once; with PIC_AUTO_EOI_EN, the next write is 8'h20 with A0=0.
REQ-034 INT deasserted during GAP -> INTA2 and CAPTURE still occur; the block returns to READY.
REQ-035 reset asserted during the ICW2 W_STROBE cycle -> WD=1 and data_bus high-Z in the same cycle; the block idles until a new start.
REQ-036 start pulsed during INTA1 -> ignored; a start after READY is reached re-runs the full init.
